bcd_digit_entry: RTL

//   Keypad-style BCD entry front end for the seven-segment display path. It is the writer feeding the sevenseg readers.
//   A digit is set on switches and committed with a debounced active-low KEY press.

---
 rtl/bcd_digit_entry_if.sv | 27 ++
 rtl/bcd_digit_entry.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_entry_if.sv
// Bus between the keypad BCD entry block and its consumer: raw key/switch
// inputs in, packed BCD digits, blank mask and status pulses out.
interface bcd_digit_entry_if #(
  parameter int NUM_DIGITS = 6
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [3:0]              digit_in;
  logic                    enter_n;
  logic                    clear_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic [CW-1:0]           digit_count;
  logic                    full;
  logic                    done;
  logic                    err;

  modport master (
    output digit_in, enter_n, clear_n,
    input  value, blank, digit_count, full, done, err
  );

  modport slave (
    input  digit_in, enter_n, clear_n,
    output value, blank, digit_count, full, done, err
  );
endinterface

// File: rtl/bcd_digit_entry.sv
// Keypad-style BCD entry: two debounced active-low keys commit or clear digits
// that shift into a packed BCD register with a per-digit blank mask.

module bcd_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       settle_q, settle_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;

    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A key held through reset must be seen released before it may strobe;
    // settle_q masks the reset value still sitting in the synchronizer.
    armed_d = armed_q | ((settle_q == 2'd2) & sync2_q);
    press_d = armed_q & deb_q & ~deb_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      deb_q    <= 1'b1;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
      settle_q <= settle_d;
    end
  end

  assign press = press_q;
endmodule

module bcd_digit_entry #(
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic              clk,
  input logic              reset,
  bcd_digit_entry_if.slave bus
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [0:0] ST_ENTRY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic commit;
  logic clr;

  bcd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.enter_n),
    .press (commit)
  );

  bcd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.clear_n),
    .press (clr)
  );

  logic [0:0]            state_q, state_d;
  logic [VW-1:0]         value_q, value_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  live_q, live_d;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    live_d  = 1'b1;

    // Clear outranks a same-cycle commit, which is dropped without err.
    if (clr) begin
      state_d = ST_ENTRY;
      value_d = '0;
      count_d = '0;
    end else if (commit) begin
      case (state_q)
        ST_ENTRY: begin
          if (bus.digit_in > 4'd9) begin
            err_d = 1'b1;
          end else begin
            value_d = {value_q[VW-5:0], bus.digit_in};
            count_d = count_q + CW'(1);
            if (count_d == CW'(NUM_DIGITS)) begin
              state_d = ST_FULL;
              done_d  = 1'b1;
            end
          end
        end
        ST_FULL: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = ST_ENTRY;
        end
      endcase
    end

    full_d = (state_d == ST_FULL);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank_d[i] = (CW'(i) >= count_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ENTRY;
      value_q <= '0;
      count_q <= '0;
      blank_q <= '1;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      blank_q <= blank_d;
      full_q  <= full_d;
      done_q  <= done_d;
      err_q   <= err_d;
      live_q  <= live_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && live_q) begin
      assert (!(done_q && err_q));
      assert (count_q <= CW'(NUM_DIGITS));
      assert (full_q == (count_q == CW'(NUM_DIGITS)));
    end
  end

  assign bus.value       = value_q;
  assign bus.blank       = blank_q;
  assign bus.digit_count = count_q;
  assign bus.full        = full_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule
